word_bank_scanner: RTL
======================

// Module: word_bank_scanner
// PURPOSE
//  Upstream feeder for the 8:1 x 4-bit select mux: holds eight 4-bit words (w0..w7) and
//  drives the mux select lines {s2,s1,s0}. Words are loaded by address. Select advances
//  automatically (auto-scan, fixed dwell per channel) or one step per pulse (manual).
//  Typical use: time-multiplexed display or channel readout.
// PARAMETERS
//  WIDTH  4  bits per stored word (mux data width)
//  DWELL  4  clock cycles each channel stays selected in auto-scan; legal range >= 1
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high reset
//  wr_en       in   1      write wr_data into word[wr_addr] this cycle
//  wr_addr     in   3      word index 0..7
//  wr_data     in   WIDTH  data to store
//  clear       in   1      synchronous clear of bank, select and state
//  run         in   1      1 = auto-scan, 0 = manual/hold
//  step        in   1      manual advance request (sampled level, one advance per high cycle)
//  w0..w7      out  WIDTH  stored words, wired to mux data inputs
//  s2,s1,s0    out  1      select to mux, {s2,s1,s0} = current channel
//  frame_done  out  1      1-cycle pulse when select wraps 7 -> 0
//  all_loaded  out  1      every word written at least once since reset/clear
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-scan): w0..w7=0, sel=0, dwell count=0, state=IDLE,
//    frame_done=0, written mask=0 (all_loaded=0). All outputs registered.
//  - Priority per cycle: reset > clear > write/advance. clear: same zeroing as reset, 1 cycle.
//  - Write: word[wr_addr] <= wr_data on edge; visible on wX one cycle after wr_en high.
//    Write and advance in the same cycle are independent; writing the currently selected
//    word is legal, new value appears next cycle. wr_en with clear: clear wins, write lost.
//  - FSM states: IDLE, SCAN.
//    IDLE: sel held; step=1 -> sel <= sel+1 (mod 8). run=1 -> SCAN with dwell count 0;
//          step in that same cycle is ignored.
//    SCAN: dwell count 0..DWELL-1; at DWELL-1 -> sel <= sel+1 (mod 8), count <= 0.
//          step ignored. run=0 -> IDLE, count <= 0, sel held at current value.
//  - DWELL=1: sel advances every cycle in SCAN. First advance occurs DWELL cycles after
//    entering SCAN.
//  - frame_done=1 for exactly the cycle after any 7->0 transition (scan or manual); else 0.
//  - all_loaded = AND of 8-bit written mask; mask bit set on write, cleared by reset/clear.
//  - Dwell counter width = max(1, clog2(DWELL)); never exceeds DWELL-1.
// STRUCTURE
//  - Shared package: N_CH=8, SEL_W=3, state typedef {IDLE, SCAN}.
//  - One sub-module: dwell_timer (counter with clr/en, terminal-count pulse at DWELL-1).
//  - Top holds register bank, written mask, sel register, FSM and frame_done flop.
// TESTING
//  1. Reset, write w[i]=i+8 for i=0..7 -> w0..w7 = 8..15 one cycle after each write;
//     all_loaded rises the cycle after the 8th write.
//  2. DWELL=4, run=1 from sel=0 -> sel 0,1,..,7,0 each held 4 cycles; frame_done single
//     pulse after 7->0; count stops exactly when run=0 and sel holds.
//  3. run=0, step high 3 cycles from sel=6 -> sel 7,0,1; frame_done pulse after 7->0.
//  4. Write addr 5 = 4'hA while sel=5 in SCAN -> w5=A next cycle, scan timing unchanged.
//  5. clear with wr_en addr 2 same cycle -> all words 0, sel=0, all_loaded=0, IDLE.
//  6. Assert reset asynchronously mid-dwell at sel=3 -> outputs zero immediately without
//     waiting for edge; after release, IDLE with sel=0.

Source files
------------

// File: rtl/word_bank_scanner_pkg.sv
// Shared constants and types for the word bank scanner.
// Channel count, select width, FSM states and dwell-counter sizing.
package word_bank_scanner_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Dwell counter needs at least one bit even when DWELL is 1 or 2.
  function automatic int cnt_w(input int dwell);
    return (dwell <= 2) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/word_bank_scanner_dwell_timer.sv
// Dwell counter 0..DWELL-1 with clear/enable; tc flags the last cycle of a dwell.
// Count is registered, tc is decoded from it; clr overrides en.
module dwell_timer
  import word_bank_scanner_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_w(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/word_bank_scanner.sv
// Eight-word register bank plus auto/manual select sequencer feeding an 8:1 mux.
// Writes and select changes land one cycle after the request; no backpressure.
module word_bank_scanner
  import word_bank_scanner_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             run,
  input  logic             step,
  output logic [WIDTH-1:0] w0,
  output logic [WIDTH-1:0] w1,
  output logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] w3,
  output logic [WIDTH-1:0] w4,
  output logic [WIDTH-1:0] w5,
  output logic [WIDTH-1:0] w6,
  output logic [WIDTH-1:0] w7,
  output logic             s2,
  output logic             s1,
  output logic             s0,
  output logic             frame_done,
  output logic             all_loaded
);

  logic [WIDTH-1:0] bank [N_CH];
  logic [N_CH-1:0]  mask;
  logic [N_CH-1:0]  wr_onehot;
  logic [SEL_W-1:0] sel;
  state_t           state;
  logic             timer_en;
  logic             timer_clr;
  logic             dwell_tc;
  logic             advance;

  assign w0 = bank[0];
  assign w1 = bank[1];
  assign w2 = bank[2];
  assign w3 = bank[3];
  assign w4 = bank[4];
  assign w5 = bank[5];
  assign w6 = bank[6];
  assign w7 = bank[7];
  assign {s2, s1, s0} = sel;

  // Timer only runs while scanning; any other cycle parks it at zero so
  // every entry into SCAN starts a fresh dwell.
  always_comb begin
    timer_en  = (state == SCAN) && run && !clear;
    advance   = 1'b0;
    if (state == SCAN) advance = run && dwell_tc;
    else               advance = !run && step;
    wr_onehot = '0;
    wr_onehot[wr_addr] = 1'b1;
  end

  assign timer_clr = !timer_en;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (dwell_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      sel        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= advance && (sel == SEL_W'(N_CH - 1));
      if (advance) sel <= sel + SEL_W'(1);
      case (state)
        IDLE:    if (run)  state <= SCAN;
        SCAN:    if (!run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) bank[i] <= '0;
      mask       <= '0;
      all_loaded <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N_CH; i++) bank[i] <= '0;
      mask       <= '0;
      all_loaded <= 1'b0;
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
      mask          <= mask | wr_onehot;
      all_loaded    <= &(mask | wr_onehot);
    end
  end

endmodule
